// File: rtl/fechadura_pkg.sv
// Shared types for the keypad lock: keypad packets, display packets, the
// configuration record and the setup controller state encoding.
// SETUP_LOCKOUT_EN adds the LOCKOUT state to the controller enum.
package fechadura_pkg;

  // Keypad packet: digits[0] is the most recent key, unused slots hold 0xF.
  typedef struct packed {
    logic [7:0][3:0] digits;
  } senhaPac_t;

  // Six BCD digits for the display.
  typedef struct packed {
    logic [5:0][3:0] bcd;
  } bcdPac_t;

  // Active configuration. master_pin[3] is the first digit typed.
  typedef struct packed {
    logic [3:0][3:0] master_pin;
    logic            bip_status;
    logic [7:0]      auto_lock_s;
  } setupPac_t;

  localparam logic [3:0] KEY_STAR = 4'hA;

  localparam setupPac_t CFG_DEFAULT = '{
    master_pin:  16'h1234,
    bip_status:  1'b1,
    auto_lock_s: 8'd5
  };

  typedef enum logic [1:0] {
    ST_OPER,
    ST_SETUP_START,
    ST_SETUP_RUN
`ifdef SETUP_LOCKOUT_EN
    , ST_LOCKOUT
`endif
  } state_t;

  // A packet terminated by the '*' key.
  function automatic logic is_star(input senhaPac_t p);
    return p.digits[0] == KEY_STAR;
  endfunction

endpackage

// File: rtl/setup_ctrl.sv
// Setup entry controller: routes keypad strobes and the display between the
// operational and setup blocks, and owns the active configuration register.
// Optional feature: define SETUP_LOCKOUT_EN to lock the keypad after
// MAX_FAIL wrong master-pin attempts for LOCK_CYC cycles.
module setup_ctrl
  import fechadura_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000,
  parameter int LOCK_CYC    = 10000,
  parameter int MAX_FAIL    = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  input  logic      oper_busy,
  input  bcdPac_t   oper_bcd_pac,
  input  logic      setup_display_en,
  input  bcdPac_t   setup_bcd_pac,
  input  setupPac_t data_setup_new,
  input  logic      data_setup_ok,
  output logic      setup_on,
  output logic      setup_digitos_valid,
  output logic      oper_digitos_valid,
  output logic      display_en,
  output bcdPac_t   bcd_pac,
  output setupPac_t cfg,
  output logic      cfg_update,
  output logic      locked
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t          state_q, state_d;
  logic            start_cnt_q, start_cnt_d;
  logic [TW-1:0]   idle_q, idle_d;
  setupPac_t       cfg_q, cfg_d;
  logic            cfg_update_q, cfg_update_d;
  logic            disp_q;

  logic            star_pkt;
  logic            master_pkt;
  logic            disp_fall;
  logic            unused_digits;

  assign star_pkt   = digitos_valid && is_star(digitos_value);
  assign master_pkt = star_pkt && (digitos_value.digits[4:1] == cfg_q.master_pin);
  assign disp_fall  = disp_q && !setup_display_en;

  // Older keypad slots play no part in routing decisions.
  assign unused_digits = &digitos_value.digits[7:5];

`ifdef SETUP_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic [LW-1:0] lock_q, lock_d;
  logic [FW-1:0] fail_q, fail_d;

  // Fail and lockout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      fail_q <= '0;
    end else begin
      lock_q <= lock_d;
      fail_q <= fail_d;
    end
  end

  assign locked = (state_q == ST_LOCKOUT);
`else
  localparam int unused_lock_cfg = LOCK_CYC + MAX_FAIL;

  assign locked = 1'b0;
`endif

  // State, counters, configuration register and display-enable history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OPER;
      start_cnt_q  <= 1'b0;
      idle_q       <= '0;
      cfg_q        <= CFG_DEFAULT;
      cfg_update_q <= 1'b0;
      disp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      idle_q       <= idle_d;
      cfg_q        <= cfg_d;
      cfg_update_q <= cfg_update_d;
      disp_q       <= setup_display_en;
    end
  end

  // Next-state logic and output routing.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    state_d             = state_q;
    start_cnt_d         = 1'b0;
    idle_d              = '0;
    cfg_d               = cfg_q;
    cfg_update_d        = 1'b0;
    setup_on            = 1'b0;
    setup_digitos_valid = 1'b0;
    oper_digitos_valid  = 1'b0;
    display_en          = 1'b1;
    bcd_pac             = oper_bcd_pac;
`ifdef SETUP_LOCKOUT_EN
    lock_d              = '0;
    fail_d              = fail_q;
`endif

    case (state_q)
      ST_OPER: begin
        // The master packet never reaches the operational block.
        oper_digitos_valid = digitos_valid && !master_pkt;
        if (master_pkt) begin
          if (!oper_busy) begin
            state_d = ST_SETUP_START;
`ifdef SETUP_LOCKOUT_EN
            fail_d  = '0;
`endif
          end
        end else if (star_pkt) begin
`ifdef SETUP_LOCKOUT_EN
          if (fail_q != FW'(MAX_FAIL)) fail_d = fail_q + 1'b1;
          if (fail_q >= FW'(MAX_FAIL - 1)) state_d = ST_LOCKOUT;
`endif
        end
      end

      ST_SETUP_START: begin
        // Hold setup_on for two cycles while the setup block wakes up.
        setup_on    = 1'b1;
        bcd_pac     = setup_bcd_pac;
        start_cnt_d = 1'b1;
        if (start_cnt_q) begin
          start_cnt_d = 1'b0;
          state_d     = ST_SETUP_RUN;
        end
      end

      ST_SETUP_RUN: begin
        setup_digitos_valid = digitos_valid;
        display_en          = setup_display_en;
        bcd_pac             = setup_bcd_pac;
        idle_d              = digitos_valid ? '0 : idle_q + 1'b1;
        // Commit has priority over abandoning the session.
        if (data_setup_ok) begin
          cfg_d        = data_setup_new;
          cfg_update_d = 1'b1;
          state_d      = ST_OPER;
          idle_d       = '0;
        end else if (disp_fall || (!digitos_valid && idle_q == TW'(TIMEOUT_CYC - 1))) begin
          state_d = ST_OPER;
          idle_d  = '0;
        end
      end

`ifdef SETUP_LOCKOUT_EN
      ST_LOCKOUT: begin
        lock_d = lock_q + 1'b1;
        if (lock_q == LW'(LOCK_CYC - 1)) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = ST_OPER;
        end
      end
`endif

      default: state_d = ST_OPER;
    endcase
  end

  assign cfg        = cfg_q;
  assign cfg_update = cfg_update_q;

endmodule

// File: doc/setup_ctrl.md
SETUP_CTRL -- requirements
Module: setup_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 5000, setup idle cycles before forced exit.
REQ-002 Parameter: LOCK_CYC, default 10000, lockout duration in cycles.
REQ-003 Parameter: MAX_FAIL, default 3, wrong-master attempts before lockout.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 digitos_value  in  senhaPac_t  keypad packet: digits[0] newest nibble, unused nibbles 0xF.
REQ-007 digitos_valid  in  1  one-cycle packet strobe.
REQ-008 oper_busy  in  1  operational block busy (door open); blocks setup entry.
REQ-009 oper_bcd_pac  in  bcdPac_t  operational display data.
REQ-010 setup_display_en / setup_bcd_pac  in  1 / bcdPac_t  setup block display outputs.
REQ-011 data_setup_new / data_setup_ok  in  setupPac_t / 1  setup result and commit strobe.
REQ-012 setup_on  out  1  setup entry command to setup block.
REQ-013 setup_digitos_valid / oper_digitos_valid  out  1 / 1  routed keypad strobes.
REQ-014 display_en / bcd_pac  out  1 / bcdPac_t  arbitrated display.
REQ-015 cfg  out  setupPac_t  active configuration register; cfg_update  out  1  one-cycle commit pulse.
REQ-016 locked  out  1  keypad lockout active.

Function
REQ-017 FSM states: OPER, SETUP_START, SETUP_RUN, LOCKOUT; LOCKOUT exists only with the macro.
REQ-018 OPER: oper_digitos_valid = digitos_valid combinationally; display_en=1, bcd_pac=oper_bcd_pac.
REQ-019 Master packet: digitos_valid & digits[0]==0xA & digits[4:1]==cfg.master_pin; suppressed from oper_digitos_valid.
REQ-020 Master packet in OPER with oper_busy=0 -> SETUP_START next cycle, fail counter cleared; with oper_busy=1 packet dropped, state unchanged.
REQ-021 SETUP_START: setup_on=1 for exactly 2 cycles, then SETUP_RUN; keypad strobes dropped; bcd_pac=setup_bcd_pac.
REQ-022 SETUP_RUN: setup_digitos_valid = digitos_valid; display_en=setup_display_en, bcd_pac=setup_bcd_pac; oper_digitos_valid=0.
REQ-023 SETUP_RUN, data_setup_ok=1: cfg <= data_setup_new, cfg_update=1 next cycle, -> OPER.
REQ-024 SETUP_RUN, setup_display_en 1->0 without data_setup_ok: -> OPER, cfg unchanged.
REQ-025 SETUP_RUN, TIMEOUT_CYC consecutive cycles without digitos_valid: -> OPER, cfg unchanged; counter reloads on every strobe.
REQ-026 Simultaneous data_setup_ok and display_en fall or timeout: commit wins.
REQ-027 Strobe coinciding with an exit transition is forwarded to setup only, never to oper.
REQ-028 Packet with digits[0]==0xA but pin mismatch in OPER: forwarded to oper, fail counter +1 (saturating).

Reset
REQ-029 rst: state=OPER, cfg=CFG_DEFAULT, setup_on=0, cfg_update=0, locked=0, all counters 0.
REQ-030 rst mid-SETUP_START/SETUP_RUN aborts with no commit; outputs at reset values next cycle.

Configuration
REQ-031 Macro SETUP_LOCKOUT_EN defined: fail counter reaching MAX_FAIL -> LOCKOUT; locked=1, all routed strobes 0, display_en=1, bcd_pac=oper_bcd_pac; after LOCK_CYC cycles -> OPER, counter cleared.
REQ-032 Macro undefined: no fail counter, no LOCKOUT state, locked tied 0.

Structure
REQ-033 Package (existing fechadura package) holds senhaPac_t, bcdPac_t, setupPac_t, CFG_DEFAULT (master_pin 1-2-3-4), state enum.
REQ-034 Single RTL module; no sub-modules.

Verification
REQ-035 Reset, packet 1,2,3,4,* -> setup_on high 2 cycles, state SETUP_RUN, bcd_pac follows setup_bcd_pac.
REQ-036 In SETUP_RUN, data_setup_ok with master_pin 5-6-7-8 -> cfg_update 1 cycle, cfg.master_pin=5678; 1,2,3,4,* then forwarded to oper.
REQ-037 In SETUP_RUN, setup_display_en drops, no ok -> OPER, cfg==CFG_DEFAULT, cfg_update never high.
REQ-038 Enter setup, no keys for 5000 cycles -> OPER, cfg unchanged; key at cycle 4999 restarts count.
REQ-039 oper_busy=1 with master packet -> setup_on stays 0, oper_digitos_valid 0 for that packet.
REQ-040 SETUP_LOCKOUT_EN: three packets 9,9,9,9,* -> locked=1, next master packet ignored; after 10000 cycles locked=0 and master packet enters setup.
